// File: rtl/soc_uart_pkg.sv
// soc_uart_pkg: shared constants for the soc_uart peripheral.
//   - register addresses on the IO bus
//   - CTRL register bit positions (read layout and write-1-to-clear bits)
//   - interrupt source IDs
//   - 2-bit engine state encoding shared by the RX and TX engines
package soc_uart_pkg;

  localparam logic [2:0] ADDR_CTRL  = 3'd0;
  localparam logic [2:0] ADDR_RXBUF = 3'd1;
  localparam logic [2:0] ADDR_TXBUF = 3'd2;

  // CTRL read layout; bit 1 reads TX_BUSY but a written 1 clears TX_DONE.
  localparam int CTRL_RX_AVAIL   = 0;
  localparam int CTRL_TX_BUSY    = 1;
  localparam int CTRL_TX_DONE_CL = 1;
  localparam int CTRL_RX_OVERRUN = 2;
  localparam int CTRL_FRAME_ERR  = 3;
  localparam int CTRL_RX_IRQ_EN  = 4;
  localparam int CTRL_TX_IRQ_EN  = 5;

  localparam logic [2:0] IRQ_ID_NONE = 3'b000;
  localparam logic [2:0] IRQ_ID_RX   = 3'b001;
  localparam logic [2:0] IRQ_ID_TX   = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/soc_uart_rx.sv
// soc_uart_rx: 8N1 serial receiver.
//   clk, reset      : system clock, synchronous active-low reset
//   rx_in           : asynchronous serial line, idle high
//   rx_data         : received byte, valid while rx_valid is high
//   rx_valid        : one-cycle pulse at the stop-bit mid-point
//   rx_frame_err    : qualifies rx_valid; stop bit was sampled low
//   rx_state        : current engine state (exposed for debug)
module soc_uart_rx
  import soc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 416
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_frame_err,
  output uart_state_e rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta, rx_sync, rx_prev;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        // Half a bit in: still low means a real start bit, else a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d        = '0;
          rx_valid     = 1'b1;
          rx_frame_err = ~rx_sync;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign rx_data  = shift_q;
  assign rx_state = state_q;

endmodule

// File: rtl/soc_uart.sv
// soc_uart: memory-mapped 8N1 UART with CTRL / RXBUF / TXBUF registers.
//   clk, reset         : system clock, synchronous active-low reset
//   cs                 : chip select, active low
//   wr, addr, in_data  : write port (wr active low, edge-detected)
//   rd_strobe, rd_busy : read handshake, out_data is the registered result
//   rx_in, tx_out      : serial lines, idle high
//   irq, irq_id        : level interrupt and source (RX has priority)
//   debug              : {TX_BUSY, RX_AVAIL, RX_OVERRUN, FRAME_ERR, tx_state, rx_state}
//
// Read handshake: a read is accepted in any cycle where cs=0, rd_strobe=1 and
// rd_busy=0. The next cycle rd_busy is high for exactly one cycle and out_data
// already carries the selected value; out_data then holds until the next
// accepted read. Strobes seen while rd_busy=1 are dropped, not queued.
module soc_uart
  import soc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  output logic       rd_busy,
  input  logic       rd_strobe,
  input  logic       wr,
  input  logic       rx_in,
  output logic       tx_out,
  input  logic [2:0] addr,
  output logic [7:0] out_data,
  input  logic [7:0] in_data,
  output logic       irq,
  output logic [2:0] irq_id,
  output logic [7:0] debug
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [7:0]  rx_data;
  logic        rx_valid, rx_frame_err;
  uart_state_e rx_state;

  soc_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_state     (rx_state)
  );

  logic rx_avail, rx_overrun, frame_err, tx_done, rx_irq_en, tx_irq_en;
  logic [7:0] rx_buf;
  logic wr_act_q;

  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_out_d, tx_done_set;

  // A held write asserts wr_act for many cycles but only its first is taken.
  logic wr_act, wr_acc, wr_ctrl, wr_tx, tx_busy, tx_start;
  logic rd_acc, rd_rxbuf, irq_rx, irq_tx;
  logic [7:0] ctrl_val, rd_mux;

  assign wr_act   = !cs && !wr;
  assign wr_acc   = wr_act && !wr_act_q;
  assign wr_ctrl  = wr_acc && (addr == ADDR_CTRL);
  assign wr_tx    = wr_acc && (addr == ADDR_TXBUF);
  assign tx_busy  = (tx_state_q != ST_IDLE);
  assign tx_start = wr_tx && !tx_busy;
  assign rd_acc   = !cs && rd_strobe && !rd_busy;
  assign rd_rxbuf = rd_acc && (addr == ADDR_RXBUF);
  assign irq_rx   = rx_avail && rx_irq_en;
  assign irq_tx   = tx_done && tx_irq_en;

  assign ctrl_val = {2'b00, tx_irq_en, rx_irq_en, frame_err, rx_overrun, tx_busy, rx_avail};

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      ADDR_CTRL:  rd_mux = ctrl_val;
      ADDR_RXBUF: rd_mux = rx_buf;
      default:    rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_act_q   <= 1'b0;
      rd_busy    <= 1'b0;
      out_data   <= 8'h00;
      rx_avail   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_done    <= 1'b0;
      rx_irq_en  <= 1'b0;
      tx_irq_en  <= 1'b0;
      rx_buf     <= 8'h00;
      irq        <= 1'b0;
      irq_id     <= IRQ_ID_NONE;
    end else begin
      wr_act_q <= wr_act;
      rd_busy  <= rd_acc;
      if (rd_acc) out_data <= rd_mux;
      if (wr_ctrl) begin
        rx_irq_en <= in_data[CTRL_RX_IRQ_EN];
        tx_irq_en <= in_data[CTRL_TX_IRQ_EN];
        if (in_data[CTRL_FRAME_ERR])  frame_err  <= 1'b0;
        if (in_data[CTRL_RX_OVERRUN]) rx_overrun <= 1'b0;
        if (in_data[CTRL_TX_DONE_CL]) tx_done    <= 1'b0;
      end
      if (tx_start)    tx_done <= 1'b0;
      if (tx_done_set) tx_done <= 1'b1;
      // A byte landing in the same cycle as an RXBUF read replaces the
      // buffer, so RX_AVAIL stays set instead of reporting an overrun.
      if (rx_valid) begin
        if (rx_frame_err) frame_err <= 1'b1;
        if (!rx_avail || rd_rxbuf) begin
          rx_buf   <= rx_data;
          rx_avail <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rd_rxbuf) begin
        rx_avail <= 1'b0;
      end
      irq    <= irq_rx || irq_tx;
      irq_id <= irq_rx ? IRQ_ID_RX : (irq_tx ? IRQ_ID_TX : IRQ_ID_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_out     <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_out     <= tx_out_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_done_set = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (tx_start) begin
          tx_state_d = ST_START;
          tx_cnt_d   = '0;
          tx_shift_d = in_data;
        end
      end
      ST_START: begin
        if (tx_cnt_q == LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
          else                  tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d    = '0;
          tx_state_d  = ST_IDLE;
          tx_done_set = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
    endcase
    // tx_out is registered from the next state so the line is glitch-free.
    case (tx_state_d)
      ST_START: tx_out_d = 1'b0;
      ST_DATA:  tx_out_d = tx_shift_d[0];
      default:  tx_out_d = 1'b1;
    endcase
  end

  assign debug = {tx_busy, rx_avail, rx_overrun, frame_err, tx_state_q, rx_state};

endmodule

// File: tb/tb_soc_uart.sv
// tb_soc_uart: self-checking bench for soc_uart at CLKS_PER_BIT=16.
module tb_soc_uart;
  import soc_uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset, cs, rd_strobe, wr, rx_in;
  logic [2:0] addr;
  logic [7:0] in_data;
  logic rd_busy, tx_out, irq;
  logic [7:0] out_data, debug;
  logic [2:0] irq_id;

  soc_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rd_busy(rd_busy), .rd_strobe(rd_strobe),
    .wr(wr), .rx_in(rx_in), .tx_out(tx_out), .addr(addr), .out_data(out_data),
    .in_data(in_data), .irq(irq), .irq_id(irq_id), .debug(debug)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the register-visible state.
  logic m_avail = 0, m_ovr = 0, m_ferr = 0, m_txdone = 0, m_rxen = 0, m_txen = 0;
  logic [7:0] m_buf = 8'h00;
  logic [7:0] tx_exp_q[$];
  int   tx_frames = 0;
  logic mon_en = 1'b1;

  typedef struct {
    logic       do_wr;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_ctrl(input logic busy);
    return {2'b00, m_txen, m_rxen, m_ferr, m_ovr, busy, m_avail};
  endfunction

  function automatic logic exp_irq();
    return (m_avail && m_rxen) || (m_txdone && m_txen);
  endfunction

  function automatic logic [2:0] exp_irq_id();
    if (m_avail && m_rxen) return 3'b001;
    if (m_txdone && m_txen) return 3'b010;
    return 3'b000;
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b0; wr = 1'b0; addr = a; in_data = d;
    tick(1);
    cs = 1'b1; wr = 1'b1;
    tick(1);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d, output int busy_cyc);
    cs = 1'b0; rd_strobe = 1'b1; addr = a;
    tick(1);
    cs = 1'b1; rd_strobe = 1'b0;
    d = out_data;
    busy_cyc = 0;
    while (rd_busy && busy_cyc < 8) begin
      busy_cyc++;
      tick(1);
    end
  endtask

  task automatic ctrl_write(input logic [7:0] d);
    bus_write(ADDR_CTRL, d);
    m_rxen = d[4];
    m_txen = d[5];
    if (d[3]) m_ferr = 1'b0;
    if (d[2]) m_ovr = 1'b0;
    if (d[1]) m_txdone = 1'b0;
  endtask

  task automatic check_ctrl(input string name);
    logic [7:0] v; int c;
    bus_read(ADDR_CTRL, v, c);
    check8(name, v, exp_ctrl(1'b0));
  endtask

  task automatic check_rxbuf(input string name, output int busy_cyc);
    logic [7:0] v;
    bus_read(ADDR_RXBUF, v, busy_cyc);
    check8(name, v, m_buf);
    m_avail = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    bus_write(ADDR_TXBUF, b);
    tx_exp_q.push_back(b);
    m_txdone = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int k = 0;
    while (debug[7] && k < 400) begin
      tick(1);
      k++;
    end
    if (debug[7]) begin
      n_tests++; n_fail++;
      $display("FAIL tx_idle_timeout: TX_BUSY still 1 after %0d cycles", k);
    end
    m_txdone = 1'b1;
  endtask

  // Drives one serial frame, then records its delivery in the model.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    rx_in = stop;
    tick(CPB);
    rx_in = 1'b1;
    tick(4);
    if (!stop) m_ferr = 1'b1;
    if (!m_avail) begin
      m_buf = b;
      m_avail = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  // Independent serial receiver decoding every frame seen on tx_out.
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      tick(1);
      if (mon_en && reset && tx_out == 1'b0) begin
        tick(CPB / 2 - 1);
        check8("tx_start_bit", {7'b0, tx_out}, 8'h00);
        for (int i = 0; i < 8; i++) begin
          tick(CPB);
          b[i] = tx_out;
        end
        tick(CPB);
        check8("tx_stop_bit", {7'b0, tx_out}, 8'h01);
        tx_frames++;
        if (tx_exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexpected_frame: got 0x%02h expected no frame", b);
        end else begin
          check8("tx_byte", b, tx_exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] v;
    int c, f0;
    reset = 1'b0; cs = 1'b1; wr = 1'b1; rd_strobe = 1'b0; rx_in = 1'b1;
    addr = 3'd0; in_data = 8'h00;

    vecs[0] = '{1'b1, ADDR_CTRL,  8'h30, ADDR_CTRL,  8'h30};
    vecs[1] = '{1'b1, ADDR_CTRL,  8'h10, ADDR_CTRL,  8'h10};
    vecs[2] = '{1'b1, ADDR_CTRL,  8'h20, ADDR_CTRL,  8'h20};
    vecs[3] = '{1'b1, ADDR_CTRL,  8'hCF, ADDR_CTRL,  8'h00};
    vecs[4] = '{1'b1, ADDR_RXBUF, 8'h55, ADDR_CTRL,  8'h00};
    vecs[5] = '{1'b1, 3'd5,       8'hFF, 3'd5,       8'h00};
    vecs[6] = '{1'b0, 3'd0,       8'h00, 3'd3,       8'h00};
    vecs[7] = '{1'b0, 3'd0,       8'h00, 3'd7,       8'h00};
    vecs[8] = '{1'b0, 3'd0,       8'h00, ADDR_RXBUF, 8'h00};

    // Reset values
    tick(4);
    check8("rst_tx_out", {7'b0, tx_out}, 8'h01);
    check8("rst_irq", {7'b0, irq}, 8'h00);
    check8("rst_irq_id", {5'b0, irq_id}, 8'h00);
    check8("rst_rd_busy", {7'b0, rd_busy}, 8'h00);
    check8("rst_out_data", out_data, 8'h00);
    check8("rst_debug", debug, 8'h00);
    reset = 1'b1;
    tick(2);

    // Register table
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdata);
      bus_read(vecs[i].raddr, v, c);
      check8($sformatf("vec%0d_rdata", i), v, vecs[i].exp);
    end

    // TX frame 0xA5 with a rejected write while busy
    tx_write(8'hA5);
    tick(20);
    bus_write(ADDR_TXBUF, 8'h3C);
    bus_read(ADDR_CTRL, v, c);
    check8("tx_busy_ctrl", v, exp_ctrl(1'b1));
    wait_tx_idle();
    check_ctrl("tx_idle_ctrl");
    tick(200);
    check_int("tx_frame_count", tx_frames, 1);

    // RX 0x5A plus read handshake
    send_rx(8'h5A, 1'b1);
    check_ctrl("rx_avail_ctrl");
    check_rxbuf("rx_5a", c);
    check_int("rd_busy_cycles", c, 1);
    tick(5);
    check8("out_data_hold", out_data, 8'h5A);
    check_ctrl("rx_cleared_ctrl");

    // Overrun and frame error
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    check_ctrl("overrun_ctrl");
    check_rxbuf("overrun_rxbuf", c);
    send_rx(8'h33, 1'b0);
    check_ctrl("frame_err_ctrl");
    ctrl_write(8'h0C);
    check_ctrl("err_clear_ctrl");
    check_rxbuf("ferr_rxbuf", c);

    // IRQ priority
    ctrl_write(8'h30);
    tick(2);
    check8("irq_txdone", {5'b0, irq_id, irq}, {5'b0, exp_irq_id(), exp_irq()});
    fork
      send_rx(8'h77, 1'b1);
      tx_write(8'h01);
    join
    wait_tx_idle();
    tick(2);
    check8("irq_both", {5'b0, irq_id, irq}, {5'b0, exp_irq_id(), exp_irq()});
    check8("irq_both_id", {5'b0, irq_id}, 8'h01);
    check_rxbuf("irq_rxbuf", c);
    tick(2);
    check8("irq_tx_only", {5'b0, irq_id, irq}, {5'b0, exp_irq_id(), exp_irq()});
    ctrl_write(8'h32);
    tick(2);
    check8("irq_none", {5'b0, irq_id, irq}, {5'b0, exp_irq_id(), exp_irq()});
    ctrl_write(8'h00);

    // Glitch on rx_in
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    tick(30);
    check_ctrl("glitch_ctrl");
    check8("glitch_rx_state", {6'b0, debug[1:0]}, 8'h00);

    // Held writes produce exactly one frame each
    for (int h = 0; h < 2; h++) begin
      f0 = tx_frames;
      cs = 1'b0; wr = 1'b0; addr = ADDR_TXBUF;
      in_data = (h == 0) ? 8'hC3 : 8'h96;
      tx_exp_q.push_back(in_data);
      m_txdone = 1'b0;
      tick((h == 0) ? 50 : 200);
      cs = 1'b1; wr = 1'b1;
      tick(1);
      wait_tx_idle();
      tick(20);
      check_int($sformatf("held_write%0d_frames", h), tx_frames, f0 + 1);
    end

    // Randomized traffic against the model
    for (int r = 0; r < 6; r++) begin
      send_rx(8'($urandom_range(0, 255)), 1'b1);
      check_rxbuf($sformatf("rand%0d_rxbuf", r), c);
      tx_write(8'($urandom_range(0, 255)));
      wait_tx_idle();
      tick($urandom_range(1, 20));
      check_ctrl($sformatf("rand%0d_ctrl", r));
    end
    tick(20);
    check_int("tx_queue_drained", tx_exp_q.size(), 0);

    // Reset mid-frame aborts both engines
    mon_en = 1'b0;
    bus_write(ADDR_TXBUF, 8'h00);
    rx_in = 1'b0;
    tick(40);
    reset = 1'b0;
    tick(1);
    check8("abort_tx_out", {7'b0, tx_out}, 8'h01);
    check8("abort_debug", debug, 8'h00);
    rx_in = 1'b1;
    tick(2);
    reset = 1'b1;
    m_avail = 0; m_ovr = 0; m_ferr = 0; m_txdone = 0; m_rxen = 0; m_txen = 0; m_buf = 8'h00;
    tick(300);
    mon_en = 1'b1;
    check_ctrl("abort_ctrl");
    check8("abort_irq", {7'b0, irq}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
